// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: direct-mapped lookup and line fill for the 4x8 data array.
// Optional: CRITICAL_WORD_FIRST_EN starts each fill at the requested byte.
module cache_fill_ctrl #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [TAG_W+4:0] cpu_addr,
  output logic             cpu_ready,
  output logic             cpu_hit,
  output logic             mem_req,
  output logic [TAG_W+4:0] mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  output logic [1:0]       arr_line,
  output logic [2:0]       arr_blk,
  output logic [7:0]       arr_din,
  output logic             arr_wr
);

  typedef enum logic [1:0] {
    IDLE,
    HIT_RSP,
    FILL,
    MISS_RSP
  } state_t;

  state_t state, nxt;

  logic [3:0]       valid;
  logic [TAG_W-1:0] tags [4];
  logic [TAG_W-1:0] lat_tag;
  logic [1:0]       lat_line;
  logic [2:0]       lat_blk;
  logic [2:0]       fill_cnt;

  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_line;
  logic [2:0]       req_blk;
  logic             lookup_hit;
  logic             last_beat;
  logic             accept;
  logic             beat;
  logic [2:0]       fill_start;

  assign req_tag  = cpu_addr[TAG_W+4:5];
  assign req_line = cpu_addr[4:3];
  assign req_blk  = cpu_addr[2:0];

  assign lookup_hit =
    valid[req_line] && (tags[req_line] == req_tag);

  assign accept = (state == IDLE) && cpu_req;
  assign beat   = (state == FILL) && mem_ack;

`ifdef CRITICAL_WORD_FIRST_EN
  // Byte order wraps from the requested blk, so the
  // beat count cannot be read from the address counter.
  logic [2:0] beat_cnt;

  assign fill_start = req_blk;
  assign last_beat  = (beat_cnt == 3'd7);

  // Counts accepted beats independently of fill order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 3'd1;
    end
  end
`else
  assign fill_start = 3'd0;
  assign last_beat  = (fill_cnt == 3'd7);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Request latch, fill counter and tag/valid store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      lat_tag  <= '0;
      lat_line <= '0;
      lat_blk  <= '0;
      fill_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        tags[i] <= '0;
      end
    end else if (accept) begin
      lat_tag  <= req_tag;
      lat_line <= req_line;
      lat_blk  <= req_blk;
      if (!lookup_hit) begin
        // Line is invalid until its last beat lands.
        valid[req_line] <= 1'b0;
        fill_cnt        <= fill_start;
      end
    end else if (beat) begin
      fill_cnt <= fill_cnt + 3'd1;
      if (last_beat) begin
        valid[lat_line] <= 1'b1;
        tags[lat_line]  <= lat_tag;
      end
    end
  end

  // Next state and all outputs.
  always_comb begin
    nxt       = state;
    cpu_ready = 1'b0;
    cpu_hit   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    arr_line  = lat_line;
    arr_blk   = lat_blk;
    arr_din   = 8'h00;
    arr_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          nxt = lookup_hit ? HIT_RSP : FILL;
        end
      end
      HIT_RSP: begin
        cpu_ready = 1'b1;
        cpu_hit   = 1'b1;
        nxt       = IDLE;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_line, fill_cnt};
        arr_blk  = fill_cnt;
        arr_din  = mem_data;
        arr_wr   = mem_ack;
        if (mem_ack && last_beat) begin
          nxt = MISS_RSP;
        end
      end
      MISS_RSP: begin
        cpu_ready = 1'b1;
        nxt       = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

endmodule
